// File: rtl/axi_line_master_if.sv
// AXI4 master-side bus bundle (AW/W/B/AR/R) used by axi_line_master.
// The master modport drives requests and ready signals; the slave modport is its mirror.
interface axi_line_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_BITS    = 4,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3
);
  logic [ID_BITS-1:0]      awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [LEN_BITS-1:0]     awlen;
  logic [SIZE_BITS-1:0]    awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wlast;
  logic                    wready;

  logic [ID_BITS-1:0]      bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_BITS-1:0]      arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [LEN_BITS-1:0]     arlen;
  logic [SIZE_BITS-1:0]    arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_BITS-1:0]      rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rlast;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rvalid, rlast,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rvalid, rlast,
    input  rready
  );
endinterface

// File: rtl/axi_line_master.sv
// Cache-line request to AXI4 INCR burst engine with response/RLAST/ID error reporting.
// Optional watchdog enabled by defining AXI_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module axi_line_master #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          DATA_WIDTH     = 32,
  parameter int          LINE_WIDTH     = 128,
  parameter int          ID_BITS        = 4,
  parameter int unsigned ID_VALUE       = 0,
  parameter int          LEN_BITS       = 8,
  parameter int          SIZE_BITS      = 3,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  input  logic                  we_i,
  input  logic                  cs_i,
  output logic                  handshaked_o,
  output logic [LINE_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  axi_line_master_if.master     m
);
  localparam int BEATS = LINE_WIDTH / DATA_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFS  = $clog2(LINE_WIDTH / 8);
  localparam logic [BW-1:0]         LAST_BEAT = BW'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~((ADDR_WIDTH'(1) << OFFS) - ADDR_WIDTH'(1));
  localparam logic [ID_BITS-1:0]    ID_EXP    = ID_BITS'(ID_VALUE);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_line;
  logic [LINE_WIDTH-1:0] r_rdata;
  logic                  r_we;
  logic                  r_err;
  logic [1:0]            r_err_code;
  logic [1:0]            r_acc;
  logic [BW-1:0]         r_beat;

  logic [DATA_WIDTH-1:0] w_slice [BEATS];
  logic [LINE_WIDTH-1:0] w_line_merged;
  logic                  w_last_beat;
  logic [1:0]            w_b_code;
  logic [1:0]            w_rbeat_code;
  logic [1:0]            w_r_code;
  logic                  w_tmo_hit;

  // Per-beat view of the line buffer, and the buffer with the current R beat merged in
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign w_slice[gi] = r_line[gi*DATA_WIDTH +: DATA_WIDTH];
      assign w_line_merged[gi*DATA_WIDTH +: DATA_WIDTH] =
        (r_beat == BW'(gi)) ? m.rdata : r_line[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_last_beat  = (r_beat == LAST_BEAT);
  assign w_b_code     = (m.bresp != 2'b00) ? 2'b01 :
                        (m.bid != ID_EXP)  ? 2'b10 : 2'b00;
  assign w_rbeat_code = (m.rresp != 2'b00) ? 2'b01 :
                        ((m.rid != ID_EXP) || (m.rlast != w_last_beat)) ? 2'b10 : 2'b00;
  // The first beat that reported anything keeps its code for the whole burst
  assign w_r_code     = (r_acc != 2'b00) ? r_acc : w_rbeat_code;

`ifdef AXI_TIMEOUT_EN
  logic [31:0] r_tmo;
  logic        w_chan_state;
  logic        w_hs;

  assign w_chan_state = r_state inside {S_AW, S_W, S_B, S_AR, S_R};
  assign w_hs = (m.awvalid && m.awready) || (m.wvalid && m.wready) ||
                (m.bvalid && m.bready)   || (m.arvalid && m.arready) ||
                (m.rvalid && m.rready);
  assign w_tmo_hit = w_chan_state && !w_hs && (r_tmo == 32'(TIMEOUT_CYCLES - 1));

  // Every state change happens on a handshake, so clearing on handshakes covers both
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo <= '0;
    end else if (!w_chan_state || w_hs || w_tmo_hit) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 32'd1;
    end
  end
`else
  logic w_unused_tmo;
  assign w_tmo_hit    = 1'b0;
  assign w_unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_line     <= '0;
      r_rdata    <= '0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_acc      <= 2'b00;
      r_beat     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cs_i) begin
            r_addr  <= addr_i & ADDR_MASK;
            r_line  <= we_i ? wdata_i : '0;
            r_we    <= we_i;
            r_acc   <= 2'b00;
            r_state <= we_i ? S_AW : S_AR;
          end
        end
        S_AW: begin
          if (m.awready) begin
            r_beat  <= '0;
            r_state <= S_W;
          end
        end
        S_W: begin
          if (m.wready) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) r_state <= S_B;
          end
        end
        S_B: begin
          if (m.bvalid) begin
            r_err_code <= w_b_code;
            r_err      <= (w_b_code != 2'b00);
            r_state    <= S_DONE;
          end
        end
        S_AR: begin
          if (m.arready) begin
            r_beat  <= '0;
            r_state <= S_R;
          end
        end
        S_R: begin
          if (m.rvalid) begin
            r_line <= w_line_merged;
            r_beat <= r_beat + 1'b1;
            r_acc  <= w_r_code;
            if (w_last_beat || m.rlast) begin
              r_rdata    <= w_line_merged;
              r_err_code <= w_r_code;
              r_err      <= (w_r_code != 2'b00);
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_tmo_hit) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b11;
        r_state    <= S_DONE;
        if (!r_we) r_rdata <= r_line;
      end
    end
  end

  assign handshaked_o = rst_ni && (r_state == S_IDLE) && cs_i;
  assign busy_o       = (r_state != S_IDLE);
  assign done_o       = (r_state == S_DONE);
  assign rvalid_o     = (r_state == S_DONE) && !r_we;
  assign rdata_o      = r_rdata;
  assign err_o        = r_err;
  assign err_code_o   = r_err_code;

  assign m.awid    = ID_EXP;
  assign m.awaddr  = r_addr;
  assign m.awlen   = LEN_BITS'(BEATS - 1);
  assign m.awsize  = SIZE_BITS'($clog2(DATA_WIDTH / 8));
  assign m.awburst = 2'b01;
  assign m.awvalid = (r_state == S_AW);

  assign m.wdata   = w_slice[r_beat];
  assign m.wstrb   = '1;
  assign m.wvalid  = (r_state == S_W);
  assign m.wlast   = (r_state == S_W) && w_last_beat;

  assign m.bready  = (r_state == S_B);

  assign m.arid    = ID_EXP;
  assign m.araddr  = r_addr;
  assign m.arlen   = LEN_BITS'(BEATS - 1);
  assign m.arsize  = SIZE_BITS'($clog2(DATA_WIDTH / 8));
  assign m.arburst = 2'b01;
  assign m.arvalid = (r_state == S_AR);

  assign m.rready  = (r_state == S_R);
endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
- Parametrised AXI4 master engine that turns single cache-line requests (addr/wdata/we/cs) from a CPU or cache into AXI INCR bursts of DATA_WIDTH beats.
- It is the generalised successor of the fixed-width CPU-side bus interface.
- It sits between a cache/core and the interconnect master port, and adds configurable line and bus widths.
- It also adds response-error reporting, RLAST/ID checking and an optional watchdog.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, AXI data bus width (bits). Must be a power of 2 and at least 8.
- LINE_WIDTH, 128, request line width. BEATS = LINE_WIDTH/DATA_WIDTH, a power of 2, 1..256.
- ID_BITS, 4, AXI ID width.
- ID_VALUE, 0, ID driven on AWID/ARID and expected on BID/RID.
- LEN_BITS, 8, AxLEN width.
- SIZE_BITS, 3, AxSIZE width.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with AXI_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- addr_i  in  ADDR_WIDTH  request address
- wdata_i  in  LINE_WIDTH  write line
- we_i  in  1  1 = write, 0 = read
- cs_i  in  1  request valid
- handshaked_o  out  1  one-cycle pulse: request accepted
- rdata_o  out  LINE_WIDTH  assembled read line
- rvalid_o  out  1  one-cycle pulse: read line complete
- done_o  out  1  one-cycle pulse: any transaction complete
- busy_o  out  1  high while not IDLE
- err_o  out  1  error status of the last transaction, valid with done_o
- err_code_o  out  2  00 OK, 01 SLVERR/DECERR, 10 protocol (RLAST/ID), 11 timeout
- m_aw*: id/addr/len/size/burst/valid out, ready in
- m_w*: data/strb/valid/last out, ready in
- m_b*: id/resp(2)/valid in, ready out
- m_ar*: id/addr/len/size/burst/valid out, ready in
- m_r*: id/data/resp(2)/valid/last in, ready out

Behaviour:
- Reset: state IDLE; all valid/ready outputs 0; handshaked_o, rvalid_o, done_o, busy_o and err_o are 0; err_code_o = 00; rdata_o = 0; beat counter = 0.
  - Reset applies immediately, including mid-burst. No completion pulse is emitted.
- Constant outputs:
  - AxLEN = BEATS-1.
  - AxSIZE = log2(DATA_WIDTH/8).
  - AxBURST = 01 (INCR).
  - AxID = ID_VALUE.
  - WSTRB = all ones.
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - When cs_i = 1, latch addr_i with its low log2(LINE_WIDTH/8) bits zeroed, and latch wdata_i and we_i.
  - Pulse handshaked_o in the same cycle.
  - Next state is AW if we_i = 1, otherwise AR.
  - cs_i is ignored in every other state.
- AW: awvalid = 1 until awready = 1; then go to W with beat counter = 0.
- W:
  - wdata = line[beat*DATA_WIDTH +: DATA_WIDTH]; wvalid = 1.
  - wlast = 1 when beat == BEATS-1.
  - On wready, increment the beat counter. After the last beat, go to B.
- B:
  - bready = 1. On bvalid, record the error:
    - bresp != 00 gives code 01;
    - otherwise bid != ID_VALUE gives code 10.
  - Then go to DONE.
- AR: arvalid = 1 until arready = 1; then go to R with beat counter = 0.
- R:
  - rready = 1. On each rvalid beat, write rdata into line[beat*DATA_WIDTH +: DATA_WIDTH].
  - Error priority (earliest beat wins; a non-zero rresp outranks code 10 on the same beat):
    - any rresp != 00 gives code 01;
    - rlast == 1 before the final beat, rlast == 0 on the final beat, or rid mismatch gives code 10.
  - Early rlast ends the burst immediately.
  - On the final or early-terminating beat, go to DONE.
- DONE (one cycle):
  - done_o = 1; err_o and err_code_o are updated.
  - For a read, rvalid_o = 1 and rdata_o is loaded from the line buffer.
  - rdata_o holds until the next read completes.
  - Next state IDLE. A new request can be accepted in the following cycle.
- Latency with a zero-wait slave:
  - Read: handshake cycle 0, AR cycle 1, R beats cycles 2..BEATS+1, rvalid_o in cycle BEATS+2.
  - Write: done_o in cycle BEATS+3.
- Valids never drop before their handshake, and payload signals stay stable while valid is high.

Optional Feature:
- Macro: AXI_TIMEOUT_EN.
- Defined:
  - A counter runs in AW, W, B, AR and R. It clears on every handshake of that channel and on state change.
  - When it reaches TIMEOUT_CYCLES, all valid/ready outputs drop next cycle and the FSM goes to DONE with err_o = 1 and err_code_o = 11.
  - For a read, rvalid_o still pulses, with a partial line.
- Undefined: no counter; the FSM waits indefinitely and code 11 is never produced.

Test Plan:
- Read, DATA_WIDTH = 32, LINE_WIDTH = 128, addr 0x1000_0014, zero-wait slave returning 0x11, 0x22, 0x33, 0x44 -> araddr 0x1000_0010, arlen 3, arsize 2; rvalid_o in cycle 6; rdata_o = 0x00000044_00000033_00000022_00000011; err_o = 0.
- Write of line 0xDDDD_CCCC_BBBB_AAAA... with awready/wready stalled 3 cycles each -> beats emitted low word first, wlast only on beat 3, payload stable during stalls; done_o after bvalid; err_code_o = 00.
- Read with rresp = 10 on beat 1 -> all 4 beats consumed; err_o = 1, err_code_o = 01.
- Read with rlast = 1 on beat 2 -> DONE after beat 2; err_code_o = 10; next request accepted normally.
- rst_ni low during W beat 2 -> wvalid = 0 immediately, busy_o = 0, no done_o; a fresh write after reset completes correctly.
- With AXI_TIMEOUT_EN and TIMEOUT_CYCLES = 16, slave never asserts arready -> arvalid drops after 16 cycles; err_code_o = 11; done_o and rvalid_o pulse.
